dtt_egress_buffer: RTL

Per-output-port egress stage placed directly downstream of `dtt_crossbar_switch`, one instance per crossbar output. The crossbar drives its outputs with no backpressure, so this block absorbs each output's `out_data`/`out_valid` stream in a small FIFO. It re-presents the data to the downstream link with a valid/ready handshake and counts words lost to overflow.

---
 rtl/dtt_xbar_pkg.sv | 20 ++
 rtl/dtt_sync_fifo.sv | 52 +++++
 rtl/dtt_egress_buffer.sv | 72 +++++++
 3 files changed

// File: rtl/dtt_xbar_pkg.sv
// rtl/dtt_xbar_pkg.sv - shared crossbar word type, default width and saturating counter helper
package dtt_xbar_pkg;

    localparam int DTT_DATA_WIDTH = 32;
    localparam int DTT_SAT_WIDTH  = 64;

    typedef logic [DTT_DATA_WIDTH-1:0] dtt_word_t;

    // Callers zero-extend a counter of `width` bits to 64 and truncate the result back.
    function automatic logic [DTT_SAT_WIDTH-1:0] dtt_sat_inc(
        input logic [DTT_SAT_WIDTH-1:0] value,
        input int                       width
    );
        logic [DTT_SAT_WIDTH-1:0] max_val;
        max_val = (width >= DTT_SAT_WIDTH) ? '1
                : ((DTT_SAT_WIDTH'(1) << width) - DTT_SAT_WIDTH'(1));
        return (value >= max_val) ? max_val : value + DTT_SAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/dtt_sync_fifo.sv
// rtl/dtt_sync_fifo.sv - first-word-fall-through FIFO storage with registered occupancy
module dtt_sync_fifo
    import dtt_xbar_pkg::*;
#(
    parameter  int DATA_WIDTH = DTT_DATA_WIDTH,
    parameter  int DEPTH      = 8,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [LVL_W-1:0]      level
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dtt_egress_buffer.sv
// rtl/dtt_egress_buffer.sv - crossbar egress FIFO with overflow drop; DTT_EGRESS_DROP_STATS_EN builds drop statistics
module dtt_egress_buffer
    import dtt_xbar_pkg::*;
#(
    parameter int DATA_WIDTH     = DTT_DATA_WIDTH,
    parameter int DEPTH          = 8,
    parameter int AF_THRESH      = 6,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count,
    output logic                        drop_pulse
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic pop;
    logic push;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);

    dtt_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (out_data),
        .level (level)
    );

    assign out_valid   = (level != '0);
    assign empty       = (level == '0);
    assign full        = (level == LVL_W'(DEPTH));
    assign almost_full = (level >= LVL_W'(AF_THRESH));

`ifdef DTT_EGRESS_DROP_STATS_EN
    logic drop;
    assign drop = in_valid && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (drop) begin
                drop_count <= DROP_CNT_WIDTH'(dtt_sat_inc(DTT_SAT_WIDTH'(drop_count), DROP_CNT_WIDTH));
            end
        end
    end
`else
    assign drop_count = '0;
    assign drop_pulse = 1'b0;
`endif

endmodule
